// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single RegFile write port between the ALU (A) and load unit (B)
// write-back requesters, registers the winning write for one cycle, and
// forwards that in-flight write onto the two read ports.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_wd,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_wd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t            pri;
  pri_t            pri_next;
  logic            s_valid;
  logic            s_valid_next;
  logic [4:0]      s_rd;
  logic [4:0]      s_rd_next;
  logic [XLEN-1:0] s_wd;
  logic [XLEN-1:0] s_wd_next;
  logic            grant_a;
  logic            grant_b;

  // Choose at most one winner per cycle; nobody is granted while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (RR_EN && (pri == PRI_B)) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next write-stage contents and priority pointer; x0 writes are granted but never enabled.
  always_comb begin
    s_valid_next = 1'b0;
    s_rd_next    = s_rd;
    s_wd_next    = s_wd;
    pri_next     = pri;
    if (grant_a) begin
      s_valid_next = (a_rd != 5'd0);
      s_rd_next    = a_rd;
      s_wd_next    = a_wd;
      if (RR_EN) begin
        pri_next = PRI_B;
      end
    end else if (grant_b) begin
      s_valid_next = (b_rd != 5'd0);
      s_rd_next    = b_rd;
      s_wd_next    = b_wd;
      if (RR_EN) begin
        pri_next = PRI_A;
      end
    end
  end

  // Write stage and priority pointer registers; reset discards any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_rd    <= '0;
      s_wd    <= '0;
      pri     <= PRI_A;
    end else begin
      s_valid <= s_valid_next;
      s_rd    <= s_rd_next;
      s_wd    <= s_wd_next;
      pri     <= pri_next;
    end
  end

  assign rf_we = s_valid;
  assign rf_rd = s_rd;
  assign rf_wd = s_wd;

  // Forward the in-flight write to matching reads; a write being discarded by reset is not forwarded.
  always_comb begin
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    if (!rst && s_valid && (rs1 != 5'd0) && (s_rd == rs1)) begin
      rd1 = s_wd;
    end
    if (!rst && s_valid && (rs2 != 5'd0) && (s_rd == rs2)) begin
      rd2 = s_wd;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Randomised and directed stimulus for the write-back arbiter. A behavioural
// model keeps architectural register contents plus the one in-flight write,
// expected RegFile writes go into a scoreboard queue, and a monitor process
// pops and compares them against the write port every cycle.
module tb_regfile_wb_arbiter;

  typedef struct {
    int          expCycle;
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aValid = 1'b0;
  logic        aReady;
  logic [4:0]  aRd = '0;
  logic [31:0] aWd = '0;
  logic        bValid = 1'b0;
  logic        bReady;
  logic [4:0]  bRd = '0;
  logic [31:0] bWd = '0;
  logic        rfWe;
  logic [4:0]  rfRd;
  logic [31:0] rfWd;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] rfRd1;
  logic [31:0] rfRd2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  // Fixed-priority instance signals
  logic        fpAValid = 1'b0;
  logic        fpAReady;
  logic [4:0]  fpARd = 5'd7;
  logic [31:0] fpAWd = '0;
  logic        fpBValid = 1'b0;
  logic        fpBReady;
  logic [4:0]  fpBRd = 5'd8;
  logic [31:0] fpBWd = '0;
  logic        fpRfWe;
  logic [4:0]  fpRfRd;
  logic [31:0] fpRfWd;
  logic [4:0]  fpRs = '0;
  logic [31:0] fpRfData = '0;
  logic [31:0] fpRd1;
  logic [31:0] fpRd2;
  bit          fpActive = 1'b0;

  // Environment RegFile and behavioural model state
  logic [31:0] rfMem [32] = '{default: 32'd0};
  logic [31:0] archRegs [32] = '{default: 32'd0};
  bit          pendValid = 1'b0;
  logic [4:0]  pendRd = '0;
  logic [31:0] pendWd = '0;
  bit          bTurn = 1'b0;
  bit          reqAActive = 1'b0;
  logic [4:0]  reqARd = '0;
  logic [31:0] reqAWd = '0;
  bit          reqBActive = 1'b0;
  logic [4:0]  reqBRd = '0;
  logic [31:0] reqBWd = '0;
  bit          expGrantA;
  bit          expGrantB;
  wr_t         sbq [$];
  int          cycleCount = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  // Values sampled mid-cycle for directed checks
  logic        sampAReady, sampBReady, sampRfWe, fpSampAReady, fpSampBReady, fpSampRfWe;
  logic [4:0]  sampRfRd, fpSampRfRd;
  logic [31:0] sampRd1, sampRd2, sampRfWd;

  regfile_wb_arbiter #(.XLEN(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(aValid), .a_ready(aReady), .a_rd(aRd), .a_wd(aWd),
    .b_valid(bValid), .b_ready(bReady), .b_rd(bRd), .b_wd(bWd),
    .rf_we(rfWe), .rf_rd(rfRd), .rf_wd(rfWd),
    .rs1(rs1), .rs2(rs2), .rf_rd1(rfRd1), .rf_rd2(rfRd2),
    .rd1(rd1), .rd2(rd2)
  );

  regfile_wb_arbiter #(.XLEN(32), .RR_EN(1'b0)) dutFixed (
    .clk(clk), .rst(rst),
    .a_valid(fpAValid), .a_ready(fpAReady), .a_rd(fpARd), .a_wd(fpAWd),
    .b_valid(fpBValid), .b_ready(fpBReady), .b_rd(fpBRd), .b_wd(fpBWd),
    .rf_we(fpRfWe), .rf_rd(fpRfRd), .rf_wd(fpRfWd),
    .rs1(fpRs), .rs2(fpRs), .rf_rd1(fpRfData), .rf_rd2(fpRfData),
    .rd1(fpRd1), .rd2(fpRd2)
  );

  always #5 clk = ~clk;

  // RegFile model: x0 reads as zero, writes are ignored while the core is in reset
  assign rfRd1 = (rs1 == 5'd0) ? 32'd0 : rfMem[rs1];
  assign rfRd2 = (rs2 == 5'd0) ? 32'd0 : rfMem[rs2];

  always @(posedge clk) begin
    if (rfWe && !rst && (rfRd != 5'd0)) rfMem[rfRd] <= rfWd;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  function automatic logic [31:0] expectedRead(input logic [4:0] rs, input bit inReset);
    if (rs == 5'd0) return 32'd0;
    if (!inReset && pendValid && (pendRd == rs)) return pendWd;
    return archRegs[rs];
  endfunction

  task automatic applyStimulus(input bit rstV,
                               input bit loadA, input logic [4:0] aRdV, input logic [31:0] aWdV,
                               input bit loadB, input logic [4:0] bRdV, input logic [31:0] bWdV,
                               input logic [4:0] r1, input logic [4:0] r2);
    rst = rstV;
    if (loadA && !reqAActive) begin
      reqAActive = 1'b1;
      reqARd     = aRdV;
      reqAWd     = aWdV;
    end
    if (loadB && !reqBActive) begin
      reqBActive = 1'b1;
      reqBRd     = bRdV;
      reqBWd     = bWdV;
    end
    aValid = reqAActive;
    aRd    = reqARd;
    aWd    = reqAWd;
    bValid = reqBActive;
    bRd    = reqBRd;
    bWd    = reqBWd;
    rs1    = r1;
    rs2    = r2;
    fpAValid = fpActive;
    fpBValid = fpActive;
    fpAWd    = $urandom;
    fpBWd    = $urandom;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance the model at posedge
  task automatic stepCycle(input bit rstV,
                           input bit loadA, input logic [4:0] aRdV, input logic [31:0] aWdV,
                           input bit loadB, input logic [4:0] bRdV, input logic [31:0] bWdV,
                           input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    applyStimulus(rstV, loadA, aRdV, aWdV, loadB, bRdV, bWdV, r1, r2);
    expGrantA = 1'b0;
    expGrantB = 1'b0;
    if (!rstV) begin
      if (reqAActive && reqBActive) begin
        if (bTurn) expGrantB = 1'b1;
        else expGrantA = 1'b1;
      end else begin
        expGrantA = reqAActive;
        expGrantB = reqBActive;
      end
    end
    #1;
    sampAReady = aReady;   sampBReady = bReady;
    sampRd1 = rd1;         sampRd2 = rd2;
    sampRfWe = rfWe;       sampRfRd = rfRd;   sampRfWd = rfWd;
    fpSampAReady = fpAReady; fpSampBReady = fpBReady;
    fpSampRfWe = fpRfWe;     fpSampRfRd = fpRfRd;
    checkOutput("a_ready", {31'd0, aReady}, {31'd0, expGrantA});
    checkOutput("b_ready", {31'd0, bReady}, {31'd0, expGrantB});
    checkOutput("rd1", rd1, expectedRead(r1, rstV));
    checkOutput("rd2", rd2, expectedRead(r2, rstV));
    @(posedge clk);
    cycleCount++;
    if (rstV) begin
      pendValid = 1'b0;
      bTurn     = 1'b0;
    end else begin
      if (pendValid) archRegs[pendRd] = pendWd;
      pendValid = 1'b0;
      if (expGrantA) begin
        if (reqARd != 5'd0) begin
          pendValid = 1'b1; pendRd = reqARd; pendWd = reqAWd;
          sbq.push_back('{cycleCount, reqARd, reqAWd});
        end
        reqAActive = 1'b0;
        bTurn      = 1'b1;
      end else if (expGrantB) begin
        if (reqBRd != 5'd0) begin
          pendValid = 1'b1; pendRd = reqBRd; pendWd = reqBWd;
          sbq.push_back('{cycleCount, reqBRd, reqBWd});
        end
        reqBActive = 1'b0;
        bTurn      = 1'b0;
      end
    end
  endtask

  // Monitor: every cycle the write port must match the scoreboard head or stay idle
  initial begin
    wr_t head;
    forever begin
      @(negedge clk);
      #2;
      if ((sbq.size() > 0) && (sbq[0].expCycle == cycleCount)) begin
        head = sbq.pop_front();
        checkOutput("wb_we", {31'd0, rfWe}, 32'd1);
        checkOutput("wb_rd", {27'd0, rfRd}, {27'd0, head.rd});
        checkOutput("wb_wd", rfWd, head.wd);
      end else begin
        checkOutput("wb_idle_we", {31'd0, rfWe}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held two cycles with both requesters valid
    for (int k = 0; k < 2; k++) begin
      stepCycle(1'b1, 1'b1, 5'd1, 32'h0000000A, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd1, 5'd0);
      checkOutput("rst_a_ready", {31'd0, sampAReady}, 32'd0);
      checkOutput("rst_b_ready", {31'd0, sampBReady}, 32'd0);
      checkOutput("rst_rf_we", {31'd0, sampRfWe}, 32'd0);
    end
    #1;
    checkOutput("rst_rf_rd", {27'd0, rfRd}, 32'd0);
    checkOutput("rst_rf_wd", rfWd, 32'd0);

    // First grant after reset goes to A (x1 = 0x0A), then B's x0 write
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    checkOutput("first_grant_a", {31'd0, sampAReady}, 32'd1);
    checkOutput("first_grant_not_b", {31'd0, sampBReady}, 32'd0);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    checkOutput("single_rf_we", {31'd0, sampRfWe}, 32'd1);
    checkOutput("single_rf_rd", {27'd0, sampRfRd}, 32'd1);
    checkOutput("single_bypass_rd1", sampRd1, 32'h0000000A);
    checkOutput("x0_b_ready", {31'd0, sampBReady}, 32'd1);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    checkOutput("x0_no_rf_we", {31'd0, sampRfWe}, 32'd0);
    checkOutput("single_rf_rd1", sampRd1, 32'h0000000A);
    checkOutput("x0_read_zero", sampRd2, 32'd0);

    // Round-robin against fixed priority, both sides continuously valid
    stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    fpActive = 1'b1;
    for (int k = 0; k < 6; k++) begin
      stepCycle(1'b0, 1'b1, 5'(10 + k), $urandom, 1'b1, 5'(20 + k), $urandom, 5'(10 + k), 5'(19 + k));
      checkOutput("rr_a_ready", {31'd0, sampAReady}, ((k % 2) == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_b_ready", {31'd0, sampBReady}, ((k % 2) == 1) ? 32'd1 : 32'd0);
      checkOutput("fp_a_ready", {31'd0, fpSampAReady}, 32'd1);
      checkOutput("fp_b_ready", {31'd0, fpSampBReady}, 32'd0);
      if (k > 0) begin
        checkOutput("rr_rf_we", {31'd0, sampRfWe}, 32'd1);
        checkOutput("fp_rf_we", {31'd0, fpSampRfWe}, 32'd1);
        checkOutput("fp_rf_rd", {27'd0, fpSampRfRd}, 32'd7);
      end
    end
    fpActive = 1'b0;
    for (int k = 0; k < 2; k++) stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd25);

    // Same-register conflict: A writes x5 first, B's value persists
    stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    stepCycle(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 5'd5, 5'd5);
    checkOutput("conflict_a_first", {31'd0, sampAReady}, 32'd1);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    checkOutput("conflict_first_wd", sampRfWd, 32'h11);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    checkOutput("conflict_second_wd", sampRfWd, 32'h22);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    checkOutput("conflict_final_x5", sampRd1, 32'h22);

    // Reset lands while A's x3 write sits in the stage
    stepCycle(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    checkOutput("midrst_rf_we", {31'd0, sampRfWe}, 32'd0);
    checkOutput("midrst_x3_old", sampRd1, 32'd0);
    stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    checkOutput("midrst_x3_kept", sampRd1, 32'd0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      stepCycle(($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);

    @(negedge clk);
    #3;
    checkOutput("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and read bypass for the single-write-port `RegFile`. It shares the one write port between two write-back requesters: requester A (ALU result) and requester B (load unit). Each requester uses a valid/ready handshake. Grants are round-robin, and the granted write passes through one registered write stage. The block also forwards the in-flight write-stage value onto the two read ports, so a read in the same cycle as the RegFile write returns the new value.

## Interface
Parameters:
- `XLEN`, 32, data width of write/read data.
- `RR_EN`, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_ready`  out  1  A's write is accepted this cycle.
- `a_rd`  in  5  A's destination register.
- `a_wd`  in  XLEN  A's write data.
- `b_valid`, `b_ready`, `b_rd`, `b_wd`: same as the A signals, for requester B.
- `rf_we`  out  1  RegFile write enable.
- `rf_rd`  out  5  RegFile write address.
- `rf_wd`  out  XLEN  RegFile write data.
- `rs1`, `rs2`  in  5  read addresses; also wired directly to the RegFile read ports.
- `rf_rd1`, `rf_rd2`  in  XLEN  raw RegFile read data.
- `rd1`, `rd2`  out  XLEN  bypassed read data to the datapath.

## Operation
- State:
  - Write stage `{s_valid, s_rd, s_wd}`.
  - Priority pointer `pri`: 0 = A favoured, 1 = B favoured.
- Outputs `rf_we = s_valid`, `rf_rd = s_rd` and `rf_wd = s_wd` come directly from the stage registers.
- The stage drains every cycle, so the block never stalls on itself. At most one grant per cycle.
- Grant rule (combinational, `rst` = 0):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid with `RR_EN` = 1: grant the side selected by `pri`.
  - Both valid with `RR_EN` = 0: grant A.
- `x_ready` = grant to x. Ready depends on valid, so requesters must not wait for ready before asserting valid.
- Requesters hold `valid`, `rd` and `wd` stable until the handshake completes. The arbiter does not register requests that were not granted.
- On a grant at a posedge:
  - Stage loads the winner's `rd` and `wd`.
  - `s_valid` = 1 if the winner's `rd` != 0.
  - `pri` is set to the non-winning side (when `RR_EN` = 1).
- With no grant, `s_valid` loads 0 and `s_rd`/`s_wd` hold their values.
- x0 handling: a request with `rd` = 0 is handshaken normally and consumes the grant and the `pri` update, but it never produces `rf_we`.
- Both requesters targeting the same register: the winner writes first and the loser writes in a later cycle, so the loser's value persists. No merging.
- Bypass:
  - `rd1 = (s_valid && rs1 != 0 && s_rd == rs1) ? s_wd : rf_rd1`.
  - `rd2` is the same with `rs2` and `rf_rd2`.
  - `rs` = 0 always passes `rf_rdN` (RegFile returns 0).

## Timing
- Reset (`rst` high at a posedge):
  - `s_valid` = 0, `s_rd` = 0, `s_wd` = 0, `pri` = 0.
  - Therefore `rf_we` = 0, `rf_rd` = 0, `rf_wd` = 0.
  - `a_ready` and `b_ready` are forced to 0 while `rst` is high.
  - `rd1`/`rd2` pass `rf_rd1`/`rf_rd2` unmodified.
- Reset mid-operation discards any write in the stage; that write never reaches the RegFile.
- Latency for a handshake at posedge N:
  - `rf_we`/`rf_rd`/`rf_wd` are valid during cycle N+1.
  - RegFile contents update at posedge N+2.
  - `rd1`/`rd2` show the new value from cycle N+1 onward: via bypass in N+1, via the RegFile afterwards.
- Throughput: one write per cycle, sustained.
- Fairness: under continuous requests from both sides with `RR_EN` = 1, grants alternate A, B, A, B, and neither side waits more than one cycle.

## Test plan
- Reset: hold `rst` for 2 cycles with `a_valid` = `b_valid` = 1 -> `a_ready` = `b_ready` = 0 and `rf_we` = 0 throughout; after release, first grant goes to A (`pri` = 0).
- Single write: A writes `a_rd` = 1, `a_wd` = 0x0000000A at edge N; `rs1` = 1 -> `rf_we` = 1, `rf_rd` = 1 in cycle N+1, `rd1` = 0x0A in N+1 (bypass); after N+2 the RegFile returns 0x0A and `rf_we` = 0.
- x0 drop: B requests `rd` = 0, `wd` = 0xFFFFFFFF -> `b_ready` = 1, `rf_we` stays 0, and a read of x0 returns 0x00000000.
- Round-robin: A and B continuously valid with distinct `rd` for 6 cycles -> grant order A, B, A, B, A, B; `rf_we` high in every cycle after the first grant. With `RR_EN` = 0, A wins all 6 cycles and `b_ready` stays 0.
- Same-register conflict: A (x5 = 0x11) and B (x5 = 0x22) both valid, `pri` = 0 -> x5 is written 0x11 and then 0x22; final read of x5 = 0x22.
- Reset mid-write: handshake A (x3 = 0x33) at edge N, assert `rst` at edge N+1 -> `rf_we` is 0 from N+1 on and x3 keeps its old value.
